// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam int AE_DEFAULT = 4;
  localparam int AF_MARGIN  = 4;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 56,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read and write returns the old word, which the full-FIFO
  // simultaneous access relies on.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact count, level flags and sticky errors.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 56,
  parameter int AF_LEVEL = DEPTH - AF_MARGIN,
  parameter int AE_LEVEL = AE_DEFAULT,
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rd,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             clrErr,
  output logic             full,
  output logic             empty,
  output logic             almostFull,
  output logic             almostEmpty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_acc, rd_acc;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full        = (count == FULL_CNT);
    empty       = (count == '0);
    almostFull  = (int'(count) >= AF_LEVEL);
    almostEmpty = (int'(count) <= AE_LEVEL);
    rd_acc      = rd && !empty;
    wr_acc      = wr && (!full || rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdValid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= bump(wr_ptr);
      if (rd_acc) rd_ptr <= bump(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rdValid <= rd_acc;
      // A fresh error takes priority over a clear in the same cycle.
      if (wr && !wr_acc) overflow <= 1'b1;
      else if (clrErr)   overflow <= 1'b0;
      if (rd && !rd_acc) underflow <= 1'b1;
      else if (clrErr)   underflow <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wrData),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rdData)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: DEPTH=8/AF=6 instance for fill/drain cases, DEPTH=5 instance for wrap and reset.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, wr_a, rd_a, ce_a;
  logic [7:0] wd_a, rdd_a;
  logic       rv_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
  logic [3:0] cnt_a;

  logic       rst_b, wr_b, rd_b, ce_b;
  logic [7:0] wd_b, rdd_b;
  logic       rv_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [2:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6)) u_dut_a (
    .clk(clk), .rst(rst_a), .wr(wr_a), .wrData(wd_a), .rd(rd_a),
    .rdData(rdd_a), .rdValid(rv_a), .clrErr(ce_a), .full(full_a),
    .empty(empty_a), .almostFull(af_a), .almostEmpty(ae_a),
    .count(cnt_a), .overflow(ov_a), .underflow(un_a)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(5)) u_dut_b (
    .clk(clk), .rst(rst_b), .wr(wr_b), .wrData(wd_b), .rd(rd_b),
    .rdData(rdd_b), .rdValid(rv_b), .clrErr(ce_b), .full(full_b),
    .empty(empty_b), .almostFull(af_b), .almostEmpty(ae_b),
    .count(cnt_b), .overflow(ov_b), .underflow(un_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    rst_a = 0; wr_a = 0; rd_a = 0; ce_a = 0; wd_a = '0;
    rst_b = 0; wr_b = 0; rd_b = 0; ce_b = 0; wd_b = '0;
  endtask

  // One clock of access on instance b (sel=1) or a (sel=0); checks happen after return.
  task automatic op(input bit sel, input logic w, input logic [7:0] d,
                    input logic r, input logic ce, input logic rs);
    @(negedge clk);
    if (sel) begin wr_b = w; wd_b = d; rd_b = r; ce_b = ce; rst_b = rs; end
    else     begin wr_a = w; wd_a = d; rd_a = r; ce_a = ce; rst_a = rs; end
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    logic [7:0] exp_d;
    idle_all();

    // Reset / idle
    op(0, 0, 0, 0, 0, 1); op(1, 0, 0, 0, 0, 1);
    op(0, 0, 0, 0, 0, 1); op(1, 0, 0, 0, 0, 1);
    chk("rst_empty", empty_a, 1); chk("rst_full", full_a, 0);
    chk("rst_count", cnt_a, 0);   chk("rst_rddata", rdd_a, 0);
    chk("rst_rdvalid", rv_a, 0);  chk("rst_ovf", ov_a, 0);
    chk("rst_unf", un_a, 0);      chk("rst_ae", ae_a, 1);
    chk("rst_af", af_a, 0);

    // Fill then overflow
    for (int i = 1; i <= 8; i++) begin
      exp_d = 8'(i);
      op(0, 1, exp_d, 0, 0, 0);
      chk("fill_count", cnt_a, 32'(i));
      chk("fill_af", af_a, (i >= 6) ? 1 : 0);
      chk("fill_ae", ae_a, (i <= 4) ? 1 : 0);
    end
    chk("fill_full", full_a, 1);
    op(0, 1, 8'h09, 0, 0, 0);
    chk("ovf_flag", ov_a, 1); chk("ovf_count", cnt_a, 8); chk("ovf_unf", un_a, 0);

    // Drain and underflow
    for (int i = 1; i <= 8; i++) begin
      op(0, 0, 0, 1, 0, 0);
      chk("drain_data", rdd_a, 32'(i));
      chk("drain_valid", rv_a, 1);
      chk("drain_count", cnt_a, 32'(8 - i));
    end
    chk("drain_empty", empty_a, 1);
    op(0, 0, 0, 1, 0, 0);
    chk("unf_flag", un_a, 1); chk("unf_valid", rv_a, 0); chk("unf_hold", rdd_a, 8'h08);
    op(0, 0, 0, 0, 1, 0);
    chk("clr_ovf", ov_a, 0); chk("clr_unf", un_a, 0);

    // Simultaneous at full
    for (int i = 0; i < 8; i++) begin
      exp_d = 8'h10 + 8'(i);
      op(0, 1, exp_d, 0, 0, 0);
    end
    chk("sf_prefull", full_a, 1);
    op(0, 1, 8'hAA, 1, 0, 0);
    chk("sf_data", rdd_a, 8'h10); chk("sf_valid", rv_a, 1);
    chk("sf_count", cnt_a, 8);    chk("sf_ovf", ov_a, 0);
    for (int j = 0; j < 8; j++) begin
      exp_d = (j < 7) ? 8'h11 + 8'(j) : 8'hAA;
      op(0, 0, 0, 1, 0, 0);
      chk("sf_drain", rdd_a, exp_d);
    end
    chk("sf_empty", empty_a, 1);

    // Simultaneous at empty
    op(0, 1, 8'h55, 1, 0, 0);
    chk("se_count", cnt_a, 1); chk("se_unf", un_a, 1); chk("se_valid", rv_a, 0);
    op(0, 0, 0, 1, 0, 0);
    chk("se_data", rdd_a, 8'h55); chk("se_valid2", rv_a, 1); chk("se_count2", cnt_a, 0);

    // Odd depth: wrap, mid-stream reset, error clear (AF=1, AE=4)
    chk("b_af0", af_b, 0); chk("b_ae0", ae_b, 1);
    op(1, 1, 8'h30, 0, 0, 0);
    op(1, 1, 8'h31, 0, 0, 0);
    chk("b_count2", cnt_b, 2); chk("b_af2", af_b, 1);
    for (int k = 0; k < 20; k++) begin
      exp_d = 8'h30 + 8'(k);
      op(1, 1, exp_d + 8'h02, 1, 0, 0);
      chk("wrap_data", rdd_b, exp_d);
      chk("wrap_valid", rv_b, 1);
      chk("wrap_count", cnt_b, 2);
    end
    op(1, 1, 8'h46, 0, 0, 0);
    chk("b_count3", cnt_b, 3);
    op(1, 1, 8'h47, 1, 0, 1);
    chk("b_rst_count", cnt_b, 0); chk("b_rst_empty", empty_b, 1);
    chk("b_rst_valid", rv_b, 0);  chk("b_rst_data", rdd_b, 0);
    op(1, 0, 0, 1, 0, 0);
    chk("b_unf", un_b, 1); chk("b_unf_count", cnt_b, 0);
    op(1, 0, 0, 1, 1, 0);
    chk("b_clr_vs_err", un_b, 1);
    op(1, 0, 0, 0, 1, 0);
    chk("b_clr", un_b, 0);
    op(1, 1, 8'h60, 0, 0, 0);
    op(1, 0, 0, 1, 0, 0);
    chk("b_post_rst_data", rdd_b, 8'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor to the fixed 8-bit FIFO. Adds:
- configurable width and depth, including non-power-of-two depths;
- guarded (protected) accesses;
- an exact occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a read-valid strobe.

It sits between producer and consumer blocks in the same clock domain as a drop-in buffer.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 56, number of entries (>=2, any integer)
AF_LEVEL, DEPTH-4, almostFull asserts when count >= AF_LEVEL
AE_LEVEL, 4, almostEmpty asserts when count <= AE_LEVEL

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wr  in  1  write request
wrData  in  WIDTH  write data
rd  in  1  read request
rdData  out  WIDTH  read data, registered
rdValid  out  1  high for one cycle when rdData holds newly read data
clrErr  in  1  clears the sticky error flags
full  out  1  count == DEPTH
empty  out  1  count == 0
almostFull  out  1  count >= AF_LEVEL
almostEmpty  out  1  count <= AE_LEVEL
count  out  CW  occupancy, 0..DEPTH; CW = $clog2(DEPTH+1)
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Clock and reset are fixed: single clock clk; rst is synchronous and active-high.
- Reset values (on rst, sampled at posedge clk):
  - pointers = 0, count = 0, rdData = 0, rdValid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - rst overrides every other input in the same cycle, including mid-stream; all stored data is discarded.
- Flags are combinational from count:
  - after reset: empty = 1, full = 0, almostEmpty = 1;
  - almostFull = (AF_LEVEL == 0).
- Read accept: rdAcc = rd && !empty.
- Write accept: wrAcc = wr && (!full || rdAcc). A write into a full FIFO is accepted only when it is paired with an accepted read.
- Write: on wrAcc, mem[wrPtr] <= wrData; wrPtr advances.
- Read: on rdAcc, rdData <= mem[rdPtr]; rdPtr advances; rdValid = 1 on the next cycle (one-cycle latency). Otherwise rdValid = 0 and rdData holds its previous value.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0. No power-of-two assumption.
- Count update:
  - +1 on wrAcc && !rdAcc;
  - -1 on rdAcc && !wrAcc;
  - unchanged otherwise.
  - count never exceeds DEPTH and never goes below 0.
- Simultaneous wr and rd:
  - empty: write accepted, read rejected; underflow set; count becomes 1; rdValid = 0 next cycle.
  - full: both accepted; count stays at DEPTH; the data read is the oldest entry, never the word written in the same cycle.
  - otherwise: both accepted; count unchanged.
- Errors:
  - overflow <= 1 when wr && !wrAcc;
  - underflow <= 1 when rd && !rdAcc;
  - both hold until rst or clrErr.
  - If clrErr and a new error occur in the same cycle, the new error wins (flag = 1).
- Rejected accesses change no pointer, memory location or count.
- Ordering: strict FIFO order across any number of pointer wraps.

Decomposition:
- Shared package fifo_pkg holds:
  - the count-width function (clog2-based);
  - the default level constants (AE default 4, AF margin 4).
- One sub-module, sync_fifo_ram:
  - simple dual-port memory, WIDTH x DEPTH;
  - one synchronous write port;
  - registered read with read enable, providing rdData.
- Pointer, count, flag and error logic stays in the top module.

Test Plan:
1. Reset/idle (DEPTH=8): assert rst for 2 cycles -> empty=1, full=0, count=0, rdData=0, rdValid=0, overflow=0, underflow=0, almostEmpty=1.
2. Fill then overflow (DEPTH=8, AF_LEVEL=6):
   - write 0x01..0x08 -> almostFull asserts when count reaches 6; count=8, full=1.
   - 9th write of 0x09 -> rejected, overflow=1, count stays 8.
3. Drain and underflow: 8 reads -> rdData = 0x01..0x08 in order, each one cycle after its read with rdValid=1; empty=1. A 9th read -> underflow=1, rdValid=0, rdData holds 0x08.
4. Simultaneous at full: FIFO full with 0x10..0x17; wr=rd=1 with wrData=0xAA -> rdData=0x10 next cycle, count stays 8; after a full drain, 0xAA is the last word out.
5. Simultaneous at empty: wr=rd=1 with wrData=0x55 -> count=1, underflow=1, rdValid=0. A following read -> rdData=0x55.
6. Wrap, odd depth, mid-stream reset (DEPTH=5):
   - 20 interleaved writes/reads of an incrementing pattern -> output order matches with no loss.
   - rst asserted with count=3 -> next cycle count=0, empty=1.
   - clrErr pulse -> error flags clear.
